// File: rtl/mem_stage_access_unit.sv
// Data-memory access unit for the memory/writeback stage of the 3-stage core.
// It decodes the load/store held in the memory-write pipeline register and runs
// one req/ack bus transaction per legal, aligned access. The pipeline register
// is stalled until the access completes. Faulting ops never reach the bus.
//
// Bus handshake: mem_req is a level. The unit raises it together with a stable
// address, write enable, strobes and write data, and holds all of them unchanged
// until the cycle in which mem_ack is high. mem_ack is sampled only while
// waiting, and mem_rdata is taken in that same cycle. If no ack arrives within
// TIMEOUT_CYCLES waiting cycles, the request is withdrawn and bus_error pulses.
module mem_stage_access_unit #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  opcode_mw,
   input  logic [2:0]  funct3_mw,
   input  logic [31:0] addr_mw,
   input  logic [31:0] store_data_mw,
   output logic        stall_memory_write,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        misaligned_fault,
   output logic        illegal_fault,
   output logic        bus_error,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [1:0]  dbg_state_o
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic            is_load, is_store, is_mem, legal_f3;
   logic            is_half, is_word, misaligned, valid_op;
   logic [31:0]     wdata_fmt;
   logic [3:0]      wstrb_fmt;
   logic [31:0]     load_fmt;
   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;
   logic            timeout_hit;

   logic [TO_W-1:0] cnt_q;
   logic [2:0]      f3_q;
   logic [1:0]      lo_q;
   logic            is_load_q;
   logic            mem_req_q, mem_we_q;
   logic [31:0]     mem_addr_q, mem_wdata_q;
   logic [3:0]      mem_wstrb_q;
   logic [31:0]     load_data_q;
   logic            load_valid_q, bus_error_q;

   // Decode the op on the pipeline register: legality, size and alignment.
   always_comb begin
      is_load  = (opcode_mw == OP_LOAD);
      is_store = (opcode_mw == OP_STORE);
      is_mem   = is_load | is_store;
      legal_f3 = 1'b0;
      if (is_load) begin
         case (funct3_mw)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_f3 = 1'b1;
            default:                                legal_f3 = 1'b0;
         endcase
      end else if (is_store) begin
         case (funct3_mw)
            3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
            default:                legal_f3 = 1'b0;
         endcase
      end
      is_half    = (funct3_mw[1:0] == 2'b01);
      is_word    = (funct3_mw[1:0] == 2'b10);
      // Alignment only matters for ops that are otherwise legal.
      misaligned = is_mem & legal_f3 &
                   ((is_half & addr_mw[0]) | (is_word & (addr_mw[1:0] != 2'b00)));
      valid_op   = is_mem & legal_f3 & ~misaligned;
   end

   // Replicate store data across lanes and build the byte enables.
   always_comb begin
      wdata_fmt = store_data_mw;
      wstrb_fmt = 4'b0000;
      if (is_store) begin
         case (funct3_mw[1:0])
            2'b00: begin
               wdata_fmt = {4{store_data_mw[7:0]}};
               wstrb_fmt = 4'b0001 << addr_mw[1:0];
            end
            2'b01: begin
               wdata_fmt = {2{store_data_mw[15:0]}};
               wstrb_fmt = 4'b0011 << addr_mw[1:0];
            end
            default: begin
               wdata_fmt = store_data_mw;
               wstrb_fmt = 4'b1111;
            end
         endcase
      end
   end

   // Pick the addressed lane of the read word and extend it per the latched funct3.
   always_comb begin
      case (lo_q)
         2'b00:   byte_sel = mem_rdata[7:0];
         2'b01:   byte_sel = mem_rdata[15:8];
         2'b10:   byte_sel = mem_rdata[23:16];
         default: byte_sel = mem_rdata[31:24];
      endcase
      half_sel = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (f3_q)
         3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_fmt = {24'd0, byte_sel};
         3'b101:  load_fmt = {16'd0, half_sel};
         default: load_fmt = mem_rdata;
      endcase
   end

   assign timeout_hit = (cnt_q == TO_LAST);

   // Access FSM next state; DONE always returns to IDLE so the op still held
   // on the inputs during DONE is not issued a second time.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (valid_op) state_d = S_WAIT;
         S_WAIT:  if (mem_ack || timeout_hit) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Access FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Bus-side registers, timeout counter and load result; pulses clear each cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         f3_q         <= 3'b000;
         lo_q         <= 2'b00;
         is_load_q    <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 32'd0;
         mem_wdata_q  <= 32'd0;
         mem_wstrb_q  <= 4'b0000;
         load_data_q  <= 32'd0;
         load_valid_q <= 1'b0;
         bus_error_q  <= 1'b0;
      end else begin
         load_valid_q <= 1'b0;
         bus_error_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (valid_op) begin
                  mem_addr_q  <= {addr_mw[31:2], 2'b00};
                  mem_we_q    <= is_store;
                  mem_wstrb_q <= wstrb_fmt;
                  mem_wdata_q <= wdata_fmt;
                  f3_q        <= funct3_mw;
                  lo_q        <= addr_mw[1:0];
                  is_load_q   <= is_load;
                  mem_req_q   <= 1'b1;
                  cnt_q       <= '0;
               end
            end
            S_WAIT: begin
               if (mem_ack) begin
                  mem_req_q    <= 1'b0;
                  load_data_q  <= load_fmt;
                  load_valid_q <= is_load_q;
               end else if (timeout_hit) begin
                  mem_req_q    <= 1'b0;
                  bus_error_q  <= 1'b1;
                  load_data_q  <= 32'd0;
                  load_valid_q <= is_load_q;
               end else begin
                  cnt_q <= cnt_q + TO_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign stall_memory_write = ((state_q == S_IDLE) & valid_op) | (state_q == S_WAIT);
   assign misaligned_fault   = misaligned;
   assign illegal_fault      = is_mem & ~legal_f3;
   assign mem_req            = mem_req_q;
   assign mem_we             = mem_we_q;
   assign mem_addr           = mem_addr_q;
   assign mem_wdata          = mem_wdata_q;
   assign mem_wstrb          = mem_wstrb_q;
   assign load_data          = load_data_q;
   assign load_valid         = load_valid_q;
   assign bus_error          = bus_error_q;
   assign dbg_state_o        = state_q;

endmodule

// File: doc/mem_stage_access_unit.md
Name: mem_stage_access_unit

Overview:
- Memory/writeback-stage data-memory controller for the 3-stage RISC-V core.
- Consumes the opcode, funct3 and address/store data held in the memory-write pipeline register.
- Performs loads and stores over a req/ack data-memory bus, and returns sign- or zero-extended load data to writeback.
- Drives stall_memory_write, which freezes the memory-write pipeline register until the access completes.

Parameters:
- TIMEOUT_CYCLES, 255: maximum WAIT cycles before the access is abandoned with bus_error.
- TO_W, 8: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- opcode_mw  in  7  opcode from the memory-write pipeline register.
- funct3_mw  in  3  funct3 from the memory-write pipeline register.
- addr_mw  in  32  effective address computed by the ALU.
- store_data_mw  in  32  rs2 value for stores.
- stall_memory_write  out  1  holds the memory-write pipeline register; combinational.
- load_data  out  32  formatted load result; registered.
- load_valid  out  1  one-cycle pulse; load_data is valid.
- misaligned_fault  out  1  combinational; current op is misaligned.
- illegal_fault  out  1  combinational; load/store with an unsupported funct3.
- bus_error  out  1  one-cycle registered pulse on timeout.
- mem_req  out  1  bus request, level.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte enables; 0 for reads.
- mem_rdata  in  32  read data; valid with mem_ack.
- mem_ack  in  1  completion; one cycle per request.

Behaviour:
- Decode rules:
  - Load is opcode 0000011: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Store is opcode 0100011: funct3 000 SB, 001 SH, 010 SW.
  - Any other funct3 on these opcodes raises illegal_fault.
- Misalignment:
  - Halfword with addr[0]=1 is misaligned.
  - Word with addr[1:0]≠0 is misaligned.
- Faulting op (misaligned or illegal) in IDLE:
  - Fault output high, no bus transaction, no stall.
  - The instruction retires in one cycle.
- FSM states are IDLE, WAIT, DONE.
- IDLE, valid mem op:
  - stall=1.
  - At the edge: latch mem_addr, mem_we, mem_wstrb, mem_wdata, funct3 and addr[1:0]; set mem_req<=1; clear timeout counter; go to WAIT.
- WAIT:
  - stall=1, mem_req=1; address, data and strobes held stable.
  - On mem_ack: mem_req<=0, capture mem_rdata, go to DONE.
  - Without ack: counter increments.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack: mem_req<=0, bus_error<=1 for one cycle, load_data<=0, go to DONE.
- DONE:
  - stall=0; load_valid=1 for loads only.
  - Go to IDLE unconditionally.
  - The op still present on the inputs this cycle is not reissued.
- Stall equation: stall_memory_write = (IDLE & valid_mem_op) | WAIT.
- Minimum latency with ack in the first WAIT cycle: 2 stall cycles, 3 cycles total per access.
- Back-to-back memory ops: the next op is seen in the cycle after DONE and starts normally.
- Load formatting:
  - Select the byte/halfword lane by the latched addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Store lanes:
  - SB: wdata = {4{b}}, wstrb = 0001 << addr[1:0].
  - SH: wdata = {2{h}}, wstrb = 0011 << addr[1:0].
  - SW: wstrb = 1111.
- mem_ack outside WAIT is ignored.
- Non-memory opcodes: all fault outputs 0, no stall, FSM stays in IDLE.
- Reset values, applied at the next edge even mid-transaction:
  - state IDLE, counter 0.
  - mem_req 0, mem_we 0, mem_wstrb 0, mem_addr 0, mem_wdata 0.
  - load_data 0, load_valid 0, bus_error 0.
  - The pending access is abandoned.

Test Plan:
- LW addr 0x100, ack on first WAIT cycle, rdata 0xDEADBEEF -> stall high for 2 cycles; mem_addr 0x100, wstrb 0000; load_data 0xDEADBEEF with load_valid in DONE.
- LB addr 0x103, rdata 0x80FF0000 -> load_data 0xFFFFFF80. LBU at the same address -> 0x00000080. LHU addr 0x102 -> 0x000080FF.
- SB addr 0x201, store_data 0x000000AB -> mem_we 1, mem_addr 0x200, wdata 0xABABABAB, wstrb 0010. SH addr 0x202, data 0x1234 -> wstrb 1100, wdata 0x12341234.
- LW addr 0x102 -> misaligned_fault 1, stall 0, mem_req never asserted. Load with funct3 011 -> illegal_fault 1, no request.
- TIMEOUT_CYCLES=4, no ack -> mem_req high for 4 cycles, bus_error pulse, load_data 0, stall released in DONE.
- rst asserted in the 2nd WAIT cycle -> next cycle mem_req 0, state IDLE, stall equals (valid op on inputs). Also check two back-to-back SWs each produce exactly one request.
